rxe_bufctl: RTL and testbench



---
 rtl/rxe_bufctl_pkg.sv | 17 +
 rtl/rxe_bufram.sv | 32 +++
 rtl/rxe_bufctl.sv | 149 ++++++++++++++
 tb/tb_rxe_bufctl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rxe_bufctl_pkg.sv
// Shared definitions for the Ethernet receive buffer controller.
// Holds the controller state encoding and the default sizing constants.
package rxe_bufctl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RECV = 2'b01,
        DROP = 2'b10
    } state_t;

    // Minimum accepted packet length in bytes
    localparam int MINLEN_DEF = 64;

    // Width of the saturating error/miss counters
    localparam int CW_DEF = 16;

endpackage

// File: rtl/rxe_bufram.sv
// Packet buffer: 2^AW x 32 simple dual-port RAM.
// One write port and one read port whose output register is reset to zero.
// The array itself is never reset.
module rxe_bufram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // Write port, no reset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Registered read, one cycle of latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/rxe_bufctl.sv
// Ethernet receive buffer controller.
// Stores one packet from the word-write filter and keeps or discards it at
// end of packet. A kept packet is held for the CPU, and its arrival raises
// a one-cycle interrupt. Packets that arrive while the buffer is held are
// dropped.
// Optional feature: define RXE_BUFCTL_ERRCNT_EN to build the saturating
// discard/miss counters. When the macro is undefined, both count outputs
// read as zero.
module rxe_bufctl
    import rxe_bufctl_pkg::*;
#(
    parameter int AW     = 12,
    parameter int MINLEN = MINLEN_DEF,
    parameter int CW     = CW_DEF
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_v,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_data,
    input  logic [AW+1:0] i_len,
    input  logic          i_err,
    input  logic          i_clear,
    input  logic [AW-1:0] i_rd_addr,
    output logic [31:0]   o_rd_data,
    output logic          o_busy,
    output logic [AW+1:0] o_len,
    output logic          o_int,
    output logic [CW-1:0] o_err_cnt,
    output logic [CW-1:0] o_miss_cnt
);

    state_t        state;
    logic          err_r;
    logic          ovf_r;
    logic [AW-1:0] prev_addr;
    logic [AW+1:0] len_r;
    logic          fin;
    logic          keep;
    logic          wr;

    // End of packet: first enabled cycle with valid low after a start
    assign fin  = i_ce && !i_v && (state == RECV || state == DROP);
    assign keep = fin && (state == RECV) && !err_r && !i_err && !ovf_r
                  && (len_r >= (AW+2)'(MINLEN));

    // The starting word is written as well, but only when the buffer is free
    assign wr = i_ce && i_v && (((state == IDLE) && !o_busy) || (state == RECV));

    rxe_bufram #(.AW(AW)) u_ram (
        .clk   (i_clk),
        .rst   (i_reset),
        .we    (wr),
        .waddr (i_addr),
        .wdata (i_data),
        .raddr (i_rd_addr),
        .rdata (o_rd_data)
    );

    // Packet FSM with sticky flags and held-packet outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            err_r     <= 1'b0;
            ovf_r     <= 1'b0;
            prev_addr <= '0;
            len_r     <= '0;
            o_busy    <= 1'b0;
            o_len     <= '0;
            o_int     <= 1'b0;
        end else begin
            o_int <= 1'b0;
            // The clear is placed first so that a keep in the same cycle overrides it
            if (i_clear)
                o_busy <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_ce && i_v) begin
                        if (!o_busy) begin
                            state     <= RECV;
                            err_r     <= i_err;
                            ovf_r     <= 1'b0;
                            prev_addr <= i_addr;
                            len_r     <= i_len;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                RECV: begin
                    if (i_ce) begin
                        if (i_err)
                            err_r <= 1'b1;
                        if (i_v) begin
                            // A backwards step in the address means the buffer wrapped
                            if (i_addr < prev_addr)
                                ovf_r <= 1'b1;
                            prev_addr <= i_addr;
                            len_r     <= i_len;
                        end else begin
                            state <= IDLE;
                            if (keep) begin
                                o_busy <= 1'b1;
                                o_len  <= len_r;
                                o_int  <= 1'b1;
                            end
                        end
                    end
                end
                DROP: begin
                    if (i_ce && !i_v)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RXE_BUFCTL_ERRCNT_EN
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] miss_cnt;
    logic          bad_end;
    logic          miss_end;

    assign bad_end  = fin && (state == RECV) && !keep;
    assign miss_end = fin && (state == DROP);

    // Saturating discard and miss counters
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            err_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (bad_end && !(&err_cnt))
                err_cnt <= err_cnt + CW'(1);
            if (miss_end && !(&miss_cnt))
                miss_cnt <= miss_cnt + CW'(1);
        end
    end

    assign o_err_cnt  = err_cnt;
    assign o_miss_cnt = miss_cnt;
`else
    assign o_err_cnt  = '0;
    assign o_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_rxe_bufctl.sv
// Self-checking bench for rxe_bufctl: directed scenarios, then random packets,
// all compared against a packet-level reference model.
module tb_rxe_bufctl;

    localparam int AW     = 12;
    localparam int CW     = 16;
    localparam int MINLEN = 64;
    localparam int DEPTH  = 1 << AW;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_ce = 1'b0;
    logic          i_v = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [31:0]   i_data = '0;
    logic [AW+1:0] i_len = '0;
    logic          i_err = 1'b0;
    logic          i_clear = 1'b0;
    logic [AW-1:0] i_rd_addr = '0;
    logic [31:0]   o_rd_data;
    logic          o_busy;
    logic [AW+1:0] o_len;
    logic          o_int;
    logic [CW-1:0] o_err_cnt;
    logic [CW-1:0] o_miss_cnt;

    rxe_bufctl #(.AW(AW), .MINLEN(MINLEN), .CW(CW)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_ce       (i_ce),
        .i_v        (i_v),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .i_len      (i_len),
        .i_err      (i_err),
        .i_clear    (i_clear),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_busy     (o_busy),
        .o_len      (o_len),
        .o_int      (o_int),
        .o_err_cnt  (o_err_cnt),
        .o_miss_cnt (o_miss_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: buffer contents plus held-packet and counter state
    logic [31:0] mref [int];
    bit          busy_m = 1'b0;
    int          len_m  = 0;
    int          err_m  = 0;
    int          miss_m = 0;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 32'(busy_m));
        chk({tag, "_len"}, 32'(o_len), 32'(len_m));
`ifdef RXE_BUFCTL_ERRCNT_EN
        chk({tag, "_errcnt"}, 32'(o_err_cnt), 32'(err_m));
        chk({tag, "_misscnt"}, 32'(o_miss_cnt), 32'(miss_m));
`else
        chk({tag, "_errcnt"}, 32'(o_err_cnt), 32'd0);
        chk({tag, "_misscnt"}, 32'(o_miss_cnt), 32'd0);
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd"}, o_rd_data, 32'd0);
        chk({tag, "_int"}, 32'(o_int), 32'd0);
        chk_state(tag);
    endtask

    task automatic rd_chk(input string tag, input int addr);
        i_rd_addr = AW'(addr);
        tick();
        if (mref.exists(addr))
            chk(tag, o_rd_data, mref[addr]);
    endtask

    // Clock-enable-low cycles carrying garbage data and error strobes
    task automatic gap();
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
            i_ce   = 1'b0;
            i_err  = 1'($urandom_range(0, 1));
            i_data = $urandom;
            tick();
        end
        i_err = 1'b0;
    endtask

    task automatic do_clear();
        i_ce    = 1'b0;
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        busy_m  = 1'b0;
        chk_state("clear");
    endtask

    // One packet of nnib nibbles starting at word address base
    task automatic send_pkt(input string tag, input int nnib, input int base,
                            input int err_nib, input bit err_end,
                            input int clr_nib, input bit clr_end, input int rst_nib);
        bit drop;
        bit errs;
        bit ovf;
        bit good;
        int len;
        drop = busy_m;
        errs = 1'b0;
        ovf  = 1'b0;
        len  = 0;
        for (int j = 0; j < nnib; j++) begin
            if (j == rst_nib) begin
                i_ce    = 1'b0;
                i_v     = 1'b0;
                i_reset = 1'b1;
                #1;
                busy_m = 1'b0;
                len_m  = 0;
                err_m  = 0;
                miss_m = 0;
                chk_reset_outputs({tag, "_midrst"});
                tick();
                i_reset = 1'b0;
                tick();
                return;
            end
            gap();
            i_ce    = 1'b1;
            i_v     = 1'b1;
            i_addr  = AW'((base + j / 8) % DEPTH);
            i_data  = $urandom;
            i_len   = (AW+2)'(j / 2 + 1);
            i_err   = (j == err_nib);
            i_clear = (j == clr_nib);
            if (i_err)
                errs = 1'b1;
            if (!drop)
                mref[int'(i_addr)] = i_data;
            if (base + j / 8 >= DEPTH)
                ovf = 1'b1;
            len = j / 2 + 1;
            tick();
            if (i_clear)
                busy_m = 1'b0;
            i_clear = 1'b0;
            i_err   = 1'b0;
        end
        gap();
        i_ce    = 1'b1;
        i_v     = 1'b0;
        i_err   = err_end;
        i_clear = clr_end;
        tick();
        if (err_end)
            errs = 1'b1;
        good = !drop && !errs && !ovf && (len >= MINLEN);
        if (clr_end)
            busy_m = 1'b0;
        if (drop) begin
            miss_m++;
        end else if (good) begin
            busy_m = 1'b1;
            len_m  = len;
        end else begin
            err_m++;
        end
        i_ce    = 1'b0;
        i_err   = 1'b0;
        i_clear = 1'b0;
        chk({tag, "_int"}, 32'(o_int), 32'(good));
        chk_state(tag);
        tick();
        chk({tag, "_intoff"}, 32'(o_int), 32'd0);
        rd_chk({tag, "_rdfirst"}, base % DEPTH);
        rd_chk({tag, "_rdlast"}, (base + (nnib - 1) / 8) % DEPTH);
    endtask

    initial begin
        int nn;
        int bs;
        int en;
        int cn;
        // Reset state
        i_reset = 1'b1;
        tick();
        chk_reset_outputs("reset");
        tick();
        i_reset = 1'b0;
        tick();

        // 100-byte good packet at address 0
        send_pkt("good100", 200, 0, -1, 1'b0, -1, 1'b0, -1);
        do_clear();
        // 60-byte packet is too short
        send_pkt("short60", 120, 0, -1, 1'b0, -1, 1'b0, -1);
        // Error on the end cycle discards the packet
        send_pkt("errend", 200, 0, -1, 1'b1, -1, 1'b0, -1);
        // Error mid-packet
        send_pkt("errmid", 200, 100, 37, 1'b0, -1, 1'b0, -1);
        // Minimum-length packet is kept
        send_pkt("min64a", 128, 0, -1, 1'b0, -1, 1'b0, -1);
        // Arrives while held: dropped, RAM untouched
        send_pkt("drop", 200, 0, -1, 1'b0, -1, 1'b0, -1);
        do_clear();
        send_pkt("min64b", 128, 0, -1, 1'b0, -1, 1'b0, -1);
        // Clear mid-drop does not abort the drop
        send_pkt("dropclr", 100, 0, -1, 1'b0, 20, 1'b0, -1);
        // Clear coincident with a keep: keep wins
        send_pkt("clrend", 160, 50, -1, 1'b0, -1, 1'b1, -1);
        do_clear();
        // Buffer wrap flags overflow
        send_pkt("wrap", 200, DEPTH - 10, -1, 1'b0, -1, 1'b0, -1);
        // 63 bytes, just too short
        send_pkt("short63", 126, 0, -1, 1'b0, -1, 1'b0, -1);
        // Single-nibble packet
        send_pkt("onenib", 1, 7, -1, 1'b0, -1, 1'b0, -1);
        // Reset mid-packet, then an 80-byte packet
        send_pkt("rstmid", 160, 0, -1, 1'b0, -1, 1'b0, 50);
        send_pkt("good80", 160, 0, -1, 1'b0, -1, 1'b0, -1);

        // Random packets
        for (int p = 0; p < 16; p++) begin
            if ($urandom_range(0, 2) == 0)
                do_clear();
            nn = $urandom_range(1, 300);
            bs = ($urandom_range(0, 3) == 0) ? DEPTH - $urandom_range(1, 40)
                                             : $urandom_range(0, 1000);
            en = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nn - 1) : -1;
            cn = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nn - 1) : -1;
            send_pkt($sformatf("rnd%0d", p), nn, bs, en,
                     ($urandom_range(0, 5) == 0), cn,
                     ($urandom_range(0, 4) == 0), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
